nibble_bus_target: RTL and testbench

Bus responder for the CPU's external nibble bus: 11-bit address, 4-bit data, single read/write strobe. It decodes each bus cycle and serves a scratch RAM plus a small peripheral window (GPIO, 16-bit timer, status/IRQ). It sits at the far end of the CPU's `bus_addr` / `bus_data_*` pins, either in the test harness or beside the CPU on-die.

---
 rtl/nibble_bus_target.sv | 127 ++++++++++++
 tb/tb_nibble_bus_target.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_bus_target.sv
// Nibble-bus responder: scratch RAM, GPIO, 16-bit timer with snapshot shadow, status/IRQ.
// Reads return 1 clock after the address edge, writes land on that edge; no backpressure, every clock is a bus cycle.
module nibble_bus_target #(
    parameter int RAM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] bus_addr,
    input  logic        bus_rw,
    input  logic [3:0]  bus_wdata,
    output logic [3:0]  bus_rdata,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int AW = $clog2(RAM_DEPTH);

    localparam logic [10:0] A_GPO_LO = 11'h700;
    localparam logic [10:0] A_GPO_HI = 11'h701;
    localparam logic [10:0] A_GPI_LO = 11'h702;
    localparam logic [10:0] A_GPI_HI = 11'h703;
    localparam logic [10:0] A_CNT0   = 11'h704;
    localparam logic [10:0] A_SHD1   = 11'h705;
    localparam logic [10:0] A_SHD2   = 11'h706;
    localparam logic [10:0] A_SHD3   = 11'h707;
    localparam logic [10:0] A_CTRL   = 11'h708;
    localparam logic [10:0] A_STAT   = 11'h709;

    logic [3:0]    mem [RAM_DEPTH];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;

    logic [7:0]  sync1, sync2;
    logic [15:0] count;
    logic [11:0] shadow;
    logic        en, irq_en, ovf;

    logic        ctrl_wr, clr, inc, wrap, ovf_w1c;
    logic [3:0]  rd_val;

    assign ram_hit = (bus_addr < 11'(RAM_DEPTH));
    assign ram_idx = bus_addr[AW-1:0];

    assign ctrl_wr = bus_rw && (bus_addr == A_CTRL);
    assign clr     = ctrl_wr && bus_wdata[1];
    assign inc     = en && !clr;
    assign wrap    = inc && (count == 16'hFFFF);
    assign ovf_w1c = bus_rw && (bus_addr == A_STAT) && bus_wdata[0];

    assign timer_irq = ovf && irq_en;

    always_comb begin
        rd_val = 4'h0;
        if (ram_hit) begin
            rd_val = mem[ram_idx];
        end else begin
            case (bus_addr)
                A_GPO_LO: rd_val = gpio_out[3:0];
                A_GPO_HI: rd_val = gpio_out[7:4];
                A_GPI_LO: rd_val = sync2[3:0];
                A_GPI_HI: rd_val = sync2[7:4];
                A_CNT0:   rd_val = count[3:0];
                A_SHD1:   rd_val = shadow[3:0];
                A_SHD2:   rd_val = shadow[7:4];
                A_SHD3:   rd_val = shadow[11:8];
                A_CTRL:   rd_val = {1'b0, irq_en, 1'b0, en};
                A_STAT:   rd_val = {3'b000, ovf};
                default:  rd_val = 4'h0;
            endcase
        end
    end

    // RAM contents survive reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && bus_rw && ram_hit) begin
            mem[ram_idx] <= bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata <= 4'h0;
            gpio_out  <= 8'h00;
            sync1     <= 8'h00;
            sync2     <= 8'h00;
            count     <= 16'h0000;
            shadow    <= 12'h000;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;

            if (!bus_rw) begin
                bus_rdata <= rd_val;
                // Shadow captures the upper count bits from the same pre-increment value returned here.
                if (bus_addr == A_CNT0) begin
                    shadow <= count[15:4];
                end
            end

            if (bus_rw && (bus_addr == A_GPO_LO)) gpio_out[3:0] <= bus_wdata;
            if (bus_rw && (bus_addr == A_GPO_HI)) gpio_out[7:4] <= bus_wdata;

            if (ctrl_wr) begin
                en     <= bus_wdata[0];
                irq_en <= bus_wdata[2];
            end

            if (clr) begin
                count <= 16'h0000;
            end else if (inc) begin
                count <= count + 16'h0001;
            end

            // Overflow set takes priority over a simultaneous write-1-to-clear.
            if (wrap) begin
                ovf <= 1'b1;
            end else if (ovf_w1c) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_bus_target.sv
// Self-checking bench for nibble_bus_target: vector table, directed timer/GPIO/reset sequences, random RAM/GPIO traffic.
module tb_nibble_bus_target;

    localparam int RD = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] bus_addr;
    logic        bus_rw;
    logic [3:0]  bus_wdata;
    logic [3:0]  bus_rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int tests = 0;
    int fails = 0;

    nibble_bus_target #(.RAM_DEPTH(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_rw    (bus_rw),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [10:0] addr;
        logic [3:0]  wdata;
        logic [3:0]  exp;
    } vec_t;

    vec_t tbl[$];

    logic [3:0] ram_m [RD];
    logic [7:0] gpo_m;
    logic [3:0] exp_rd;

    task automatic step(input logic r, input logic rw, input logic [10:0] a, input logic [3:0] d);
        rst       = r;
        bus_rw    = rw;
        bus_addr  = a;
        bus_wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_read(input logic [10:0] a);
        if (a < 11'(RD)) return ram_m[a[7:0]];
        case (a)
            11'h700: return gpo_m[3:0];
            11'h701: return gpo_m[7:4];
            11'h702: return 4'hA;
            11'h703: return 4'h5;
            default: return 4'h0;
        endcase
    endfunction

    initial begin
        logic [3:0]  r4, r5, r6, r7;
        logic [15:0] run_n;
        logic [10:0] a;
        logic        rw;
        logic [3:0]  d;
        int          sel;

        rst = 1'b1; bus_rw = 1'b0; bus_addr = '0; bus_wdata = '0; gpio_in = 8'h00;

        // Reset with random bus activity, then every peripheral register reads 0.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 4'($urandom_range(0, 15)));
        check("reset_rdata", 32'(bus_rdata), 32'h0);
        check("reset_gpio_out", 32'(gpio_out), 32'h0);
        check("reset_irq", 32'(timer_irq), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 11'h700 + 11'(i), 4'h0);
            check($sformatf("reset_reg_%0h", 11'h700 + 11'(i)), 32'(bus_rdata), 32'h0);
        end

        // Vector table: write vectors expect the held previous read value.
        tbl.push_back({1'b1, 11'h000, 4'h6, 4'h0});
        tbl.push_back({1'b1, 11'h012, 4'hA, 4'h0});
        tbl.push_back({1'b0, 11'h012, 4'h0, 4'hA});
        tbl.push_back({1'b1, 11'h100, 4'h5, 4'hA});
        tbl.push_back({1'b0, 11'h100, 4'h0, 4'h0});
        tbl.push_back({1'b0, 11'h000, 4'h0, 4'h6});
        tbl.push_back({1'b0, 11'h3FF, 4'h0, 4'h0});
        tbl.push_back({1'b1, 11'h700, 4'h3, 4'h0});
        tbl.push_back({1'b1, 11'h701, 4'hC, 4'h0});
        tbl.push_back({1'b0, 11'h700, 4'h0, 4'h3});
        tbl.push_back({1'b0, 11'h701, 4'h0, 4'hC});
        tbl.push_back({1'b1, 11'h704, 4'h7, 4'hC});
        tbl.push_back({1'b0, 11'h704, 4'h0, 4'h0});
        tbl.push_back({1'b0, 11'h701, 4'h0, 4'hC});
        tbl.push_back({1'b1, 11'h702, 4'hF, 4'hC});
        tbl.push_back({1'b0, 11'h702, 4'h0, 4'h0});
        tbl.push_back({1'b1, 11'h708, 4'h2, 4'h0});
        tbl.push_back({1'b0, 11'h708, 4'h0, 4'h0});
        tbl.push_back({1'b1, 11'h708, 4'h4, 4'h0});
        tbl.push_back({1'b0, 11'h708, 4'h0, 4'h4});
        tbl.push_back({1'b1, 11'h708, 4'h0, 4'h4});
        tbl.push_back({1'b0, 11'h709, 4'h0, 4'h0});
        tbl.push_back({1'b0, 11'h701, 4'h0, 4'hC});
        tbl.push_back({1'b0, 11'h7FF, 4'h0, 4'h0});
        foreach (tbl[i]) begin
            step(1'b0, tbl[i].rw, tbl[i].addr, tbl[i].wdata);
            check($sformatf("vec%0d_%s_%0h", i, tbl[i].rw ? "wr" : "rd", tbl[i].addr),
                  32'(bus_rdata), 32'(tbl[i].exp));
        end
        check("gpio_out_c3", 32'(gpio_out), 32'hC3);

        // GPIO input synchronizer: new value readable from the third edge after the change.
        gpio_in = 8'h5A;
        step(1'b0, 1'b0, 11'h702, 4'h0);
        check("gpi_edge0_old", 32'(bus_rdata), 32'h0);
        step(1'b0, 1'b0, 11'h702, 4'h0);
        check("gpi_edge1_old", 32'(bus_rdata), 32'h0);
        step(1'b0, 1'b0, 11'h702, 4'h0);
        check("gpi_edge2_lo", 32'(bus_rdata), 32'hA);
        step(1'b0, 1'b0, 11'h703, 4'h0);
        check("gpi_hi", 32'(bus_rdata), 32'h5);

        // Random traffic against the reference model (timer idle, CTRL not written).
        gpo_m = 8'hC3;
        exp_rd = bus_rdata;
        for (int i = 0; i < RD; i++) begin
            d = 4'($urandom_range(0, 15));
            ram_m[i] = d;
            step(1'b0, 1'b1, 11'(i), d);
        end
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                5:       a = 11'h700 + 11'($urandom_range(0, 1));
                6:       a = 11'h702 + 11'($urandom_range(0, 7));
                7:       a = 11'($urandom_range(RD, 11'h6FF));
                8:       a = 11'($urandom_range(11'h70A, 11'h7FF));
                default: a = 11'($urandom_range(0, RD - 1));
            endcase
            rw = 1'($urandom_range(0, 1));
            if (a == 11'h708) rw = 1'b0;
            d = 4'($urandom_range(0, 15));
            if (rw) begin
                if (a < 11'(RD)) ram_m[a[7:0]] = d;
                else if (a == 11'h700) gpo_m[3:0] = d;
                else if (a == 11'h701) gpo_m[7:4] = d;
            end else begin
                exp_rd = model_read(a);
            end
            step(1'b0, rw, a, d);
            check($sformatf("rnd%0d_rdata_%0h", i, a), 32'(bus_rdata), 32'(exp_rd));
            check($sformatf("rnd%0d_gpio_out", i), 32'(gpio_out), 32'(gpo_m));
        end

        // Timer snapshot: clear+enable, run, then read the four nibbles back to back.
        run_n = 16'h1234;
        step(1'b0, 1'b1, 11'h708, 4'h3);
        for (int i = 0; i < int'(run_n); i++) step(1'b0, 1'b0, 11'h7FF, 4'h0);
        step(1'b0, 1'b0, 11'h704, 4'h0); r4 = bus_rdata;
        step(1'b0, 1'b0, 11'h705, 4'h0); r5 = bus_rdata;
        step(1'b0, 1'b0, 11'h706, 4'h0); r6 = bus_rdata;
        step(1'b0, 1'b0, 11'h707, 4'h0); r7 = bus_rdata;
        check("snapshot", 32'({r7, r6, r5, r4}), 32'(run_n));

        // Clear beats increment while running; count then resumes.
        step(1'b0, 1'b1, 11'h708, 4'h3);
        step(1'b0, 1'b0, 11'h704, 4'h0);
        check("clr_cnt0", 32'(bus_rdata), 32'h0);
        step(1'b0, 1'b0, 11'h705, 4'h0);
        check("clr_shadow", 32'(bus_rdata), 32'h0);
        step(1'b0, 1'b0, 11'h704, 4'h0);
        check("clr_resume", 32'(bus_rdata), 32'h2);

        // Reset overrides a coincident GPIO write.
        step(1'b1, 1'b1, 11'h700, 4'hF);
        check("rst_drops_write", 32'(gpio_out), 32'h0);

        // Overflow: wrap edge coincides with W1C, so ovf still sets.
        step(1'b0, 1'b1, 11'h708, 4'h7);
        for (int i = 0; i < 16'hFFFE; i++) step(1'b0, 1'b0, 11'h7FF, 4'h0);
        step(1'b0, 1'b0, 11'h708, 4'h0);
        check("ctrl_readback", 32'(bus_rdata), 32'h5);
        check("irq_before_wrap", 32'(timer_irq), 32'h0);
        step(1'b0, 1'b1, 11'h709, 4'h1);
        check("irq_after_wrap_w1c", 32'(timer_irq), 32'h1);
        step(1'b0, 1'b0, 11'h709, 4'h0);
        check("ovf_set_wins", 32'(bus_rdata), 32'h1);
        step(1'b0, 1'b1, 11'h709, 4'h1);
        check("irq_cleared", 32'(timer_irq), 32'h0);
        step(1'b0, 1'b0, 11'h709, 4'h0);
        check("ovf_cleared", 32'(bus_rdata), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
